// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state encoding, default bus timeout and the byte-lane helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY     = 3'd1,
    DONE     = 3'd2,
    DONE_ERR = 3'd3,
    DONE_TO  = 3'd4
  } lsu_state_e;

  // size: 0 = byte, 1 = halfword, otherwise word; off = byte offset in the word.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a bus read word to the accessed byte lane and sign/zero-extends it
// according to the load funct3.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    load_data_o = '0;
    case (f3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data_o = shifted;
      F3_LBU:  load_data_o = {24'd0, shifted[7:0]};
      F3_LHU:  load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns the EX/MEM access into a req/ready bus
// transaction, stalls the pipeline until it finishes and returns load data.
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_f3,
  input  logic [31:0] ex_aluresult,
  input  logic [31:0] ex_bmux_result,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

  lsu_state_e  state_q;
  logic [3:0]  wait_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        misaligned_q;
  logic        bus_error_q;

  logic        access;
  logic        legal_f3;
  logic        misalign;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_data;

  // A simultaneous read and write is treated as a load, so legality follows memread.
  always_comb begin
    access = ex_memread | ex_memwrite;
    if (ex_memread) begin
      legal_f3 = ex_f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    end else begin
      legal_f3 = ex_f3 inside {F3_SB, F3_SH, F3_SW};
    end
    misalign = ((ex_f3[1:0] == 2'b01) && ex_aluresult[0]) ||
               ((ex_f3[1:0] == 2'b10) && (ex_aluresult[1:0] != 2'b00));
    be_d = lane_be(ex_f3[1:0], ex_aluresult[1:0]);
    case (ex_f3[1:0])
      2'b00:   wdata_d = {4{ex_bmux_result[7:0]}};
      2'b01:   wdata_d = {2{ex_bmux_result[15:0]}};
      default: wdata_d = ex_bmux_result;
    endcase
  end

  assign stall = reset && (((state_q == IDLE) && access) || (state_q == BUSY));

  load_extend u_load_extend (
    .rdata_i     (mem_rdata),
    .addr_lo_i   (addr_lo_q),
    .f3_i        (f3_q),
    .load_data_o (ext_data)
  );

  // Result pulses and load data default to zero every cycle so they last exactly one DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      addr_lo_q    <= '0;
      f3_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      load_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (legal_f3 && !misalign) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= ~ex_memread;
              mem_addr_q  <= {ex_aluresult[31:2], 2'b00};
              addr_lo_q   <= ex_aluresult[1:0];
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              f3_q        <= ex_f3;
              wait_q      <= '0;
              state_q     <= BUSY;
            end else begin
              misaligned_q <= 1'b1;
              state_q      <= DONE_ERR;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (!mem_we_q) begin
              load_valid_q <= 1'b1;
              load_data_q  <= ext_data;
            end
          end else if (wait_q == WaitLast) begin
            mem_req_q   <= 1'b0;
            bus_error_q <= 1'b1;
            state_q     <= DONE_TO;
          end else if (wait_q != 4'hF) begin
            wait_q <= wait_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses compared against a byte-level behavioural model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_f3 = '0;
  logic [31:0] ex_aluresult = '0;
  logic [31:0] ex_bmux_result = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  // Observations gathered by drive()
  int          obs_stall, obs_req, obs_pulses;
  logic        obs_done, obs_unstable, obs_we, obs_lv, obs_mis, obs_berr, obs_req_done;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_be;

  // Expectations produced by model()
  int          exp_stall, exp_req;
  logic        exp_we, exp_lv, exp_mis, exp_berr;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;

  mem_stage_lsu dut (
    .clk            (clk),
    .reset          (reset),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_f3          (ex_f3),
    .ex_aluresult   (ex_aluresult),
    .ex_bmux_result (ex_bmux_result),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .misaligned     (misaligned),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  // Byte-level reference: ready_at = BUSY cycle carrying mem_ready, 0 = never.
  task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int ready_at, input logic [31:0] rdata);
    int          off, nbytes;
    logic        legal;
    logic [31:0] v, mask;
    off    = int'(addr % 4);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    if (rd) legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    else    legal = wr && (f3 <= 3'd2);
    if (legal && (off % nbytes) != 0) legal = 1'b0;
    exp_mis   = !legal;
    exp_berr  = legal && (ready_at == 0);
    exp_lv    = legal && rd && (ready_at > 0);
    exp_stall = !legal ? 1 : (ready_at == 0) ? 16 : ready_at + 1;
    exp_req   = !legal ? 0 : (ready_at == 0) ? 15 : ready_at;
    exp_we    = !rd;
    exp_addr  = addr - 32'(off);
    exp_be    = 4'(((1 << nbytes) - 1) << off);
    exp_wdata = (nbytes == 1) ? rs2[7:0] * 32'h0101_0101 :
                (nbytes == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
    exp_ld = '0;
    if (exp_lv) begin
      v    = rdata >> (8 * off);
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
      v    = v & mask;
      if (f3 < 3'd4 && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      exp_ld = v;
    end
  endtask

  // Presents one access from IDLE, plays the bus slave and records what the DUT did.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int ready_at, input logic [31:0] rdata, input logic ready_early);
    obs_stall = 0; obs_req = 0; obs_pulses = 0;
    obs_done = 0; obs_unstable = 0; obs_we = 0; obs_lv = 0; obs_mis = 0; obs_berr = 0;
    obs_req_done = 0; obs_addr = '0; obs_wdata = '0; obs_ld = '0; obs_be = '0;
    ex_memread = rd; ex_memwrite = wr; ex_f3 = f3; ex_aluresult = addr; ex_bmux_result = rs2;
    mem_ready = ready_early;
    mem_rdata = $urandom;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0 && !stall) begin
        obs_done = 1; obs_lv = load_valid; obs_mis = misaligned; obs_berr = bus_error;
        obs_ld = load_data; obs_req_done = mem_req;
        break;
      end
      if (stall) obs_stall++;
      if (load_valid || misaligned || bus_error) obs_pulses++;
      if (mem_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
        end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                     mem_wdata !== obs_wdata || mem_we !== obs_we) begin
          obs_unstable = 1;
        end
      end
      mem_ready = (mem_req && obs_req == ready_at) || (cyc == 0 && ready_early);
      mem_rdata = (mem_req && obs_req == ready_at) ? rdata : $urandom;
      @(posedge clk); #2;
    end
    ex_memread = 0; ex_memwrite = 0; mem_ready = 0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset = 0; ex_memread = 1; ex_aluresult = 32'h100; ex_f3 = 3'b010;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got=%b exp=0", mem_req); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin errors++; $display("[TB] FAIL rst_bus got=%b/%h/%h/%h exp=0", mem_we, mem_be, mem_addr, mem_wdata); end
    checks++; if ({load_valid, misaligned, bus_error, load_data} !== '0) begin errors++; $display("[TB] FAIL rst_result got=%b%b%b/%h exp=0", load_valid, misaligned, bus_error, load_data); end
    ex_memread = 0;
    reset = 1;
    @(posedge clk); #2;
  endtask

  task automatic test_lw_basic();
    drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 0);
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr got=%h exp=00000100", obs_addr); end
    checks++; if (obs_be !== 4'b1111) begin errors++; $display("[TB] FAIL lw_be got=%b exp=1111", obs_be); end
    checks++; if (obs_we !== 1'b0) begin errors++; $display("[TB] FAIL lw_we got=%b exp=0", obs_we); end
    checks++; if (obs_done !== 1'b1 || obs_lv !== 1'b1) begin errors++; $display("[TB] FAIL lw_valid got=%b/%b exp=1/1", obs_done, obs_lv); end
    checks++; if (obs_ld !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_data got=%h exp=deadbeef", obs_ld); end
    checks++; if (obs_stall !== 2) begin errors++; $display("[TB] FAIL lw_stall got=%0d exp=2", obs_stall); end
    checks++; if (obs_req_done !== 1'b0) begin errors++; $display("[TB] FAIL lw_req_drop got=%b exp=0", obs_req_done); end
  endtask

  task automatic test_lb_lbu();
    drive(1, 0, 3'b000, 32'h203, 32'h0, 2, 32'h8011_2233, 1);
    checks++; if (obs_be !== 4'b1000) begin errors++; $display("[TB] FAIL lb_be got=%b exp=1000", obs_be); end
    checks++; if (obs_addr !== 32'h200) begin errors++; $display("[TB] FAIL lb_addr got=%h exp=00000200", obs_addr); end
    checks++; if (obs_ld !== 32'hFFFF_FF80 || obs_lv !== 1'b1) begin errors++; $display("[TB] FAIL lb_data got=%h/%b exp=ffffff80/1", obs_ld, obs_lv); end
    checks++; if (obs_stall !== 3 || obs_req !== 2) begin errors++; $display("[TB] FAIL lb_timing got=%0d/%0d exp=3/2", obs_stall, obs_req); end
    drive(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h8011_2233, 0);
    checks++; if (obs_ld !== 32'h0000_0080 || obs_lv !== 1'b1) begin errors++; $display("[TB] FAIL lbu_data got=%h/%b exp=00000080/1", obs_ld, obs_lv); end
    drive(1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h9ABC_1234, 0);
    checks++; if (obs_ld !== 32'hFFFF_9ABC || obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL lh_data got=%h/%b exp=ffff9abc/1100", obs_ld, obs_be); end
  endtask

  task automatic test_sh_store();
    drive(0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 1, 32'h0, 0);
    checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL sh_we got=%b exp=1", obs_we); end
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be got=%b exp=1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    checks++; if (obs_addr !== 32'h10) begin errors++; $display("[TB] FAIL sh_addr got=%h exp=00000010", obs_addr); end
    checks++; if ({obs_lv, obs_mis, obs_berr} !== 3'b000 || obs_done !== 1'b1) begin errors++; $display("[TB] FAIL sh_nopulse got=%b%b%b done=%b exp=000 done=1", obs_lv, obs_mis, obs_berr, obs_done); end
  endtask

  task automatic test_misaligned();
    drive(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 0);
    checks++; if (obs_mis !== 1'b1 || obs_stall !== 1) begin errors++; $display("[TB] FAIL mis_pulse got=%b stall=%0d exp=1 stall=1", obs_mis, obs_stall); end
    checks++; if (obs_req !== 0 || obs_req_done !== 1'b0 || obs_ld !== '0) begin errors++; $display("[TB] FAIL mis_nobus got=req%0d/%b ld=%h exp=req0/0 ld=0", obs_req, obs_req_done, obs_ld); end
    drive(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0);
    checks++; if (obs_mis !== 1'b1 || obs_stall !== 1 || obs_req !== 0) begin errors++; $display("[TB] FAIL f3_illegal got=%b stall=%0d req=%0d exp=1/1/0", obs_mis, obs_stall, obs_req); end
    drive(0, 1, 3'b001, 32'h21, 32'h1234, 1, 32'h0, 0);
    checks++; if (obs_mis !== 1'b1 || obs_req !== 0) begin errors++; $display("[TB] FAIL sh_mis got=%b req=%0d exp=1/0", obs_mis, obs_req); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 0);
    checks++; if (obs_req !== 15) begin errors++; $display("[TB] FAIL to_req_cycles got=%0d exp=15", obs_req); end
    checks++; if (obs_berr !== 1'b1 || obs_lv !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse got=berr%b/lv%b exp=1/0", obs_berr, obs_lv); end
    checks++; if (obs_ld !== '0 || obs_req_done !== 1'b0) begin errors++; $display("[TB] FAIL to_release got=ld%h req%b exp=0/0", obs_ld, obs_req_done); end
    checks++; if (obs_stall !== 16 || obs_unstable !== 1'b0) begin errors++; $display("[TB] FAIL to_stall got=%0d unstable=%b exp=16/0", obs_stall, obs_unstable); end
  endtask

  task automatic test_reset_mid_busy();
    ex_memread = 1; ex_f3 = 3'b010; ex_aluresult = 32'h80; ex_bmux_result = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_req got=%b exp=1", mem_req); end
    reset = 0;
    @(posedge clk); #2;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req got=%b stall=%b exp=0/0", mem_req, stall); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata, load_valid, misaligned, bus_error, load_data} !== '0) begin errors++; $display("[TB] FAIL mid_rst_outs got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_be); end
    ex_memread = 0;
    reset = 1;
    @(posedge clk); #2;
    drive(0, 1, 3'b010, 32'h40, 32'h1357_9BDF, 2, 32'h0, 0);
    checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b1 || obs_addr !== 32'h40) begin errors++; $display("[TB] FAIL post_rst_sw got=%b/%b/%h exp=1111/1/00000040", obs_be, obs_we, obs_addr); end
    checks++; if (obs_wdata !== 32'h1357_9BDF || obs_done !== 1'b1 || obs_stall !== 3) begin errors++; $display("[TB] FAIL post_rst_sw_done got=%h/%b/%0d exp=13579bdf/1/3", obs_wdata, obs_done, obs_stall); end
  endtask

  task automatic test_random();
    logic        rd, wr;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          ready_at;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(1, 3));
      rd = op[0]; wr = op[1];
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      addr = $urandom; rs2 = $urandom; rdata = $urandom;
      ready_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      model(rd, wr, f3, addr, rs2, ready_at, rdata);
      drive(rd, wr, f3, addr, rs2, ready_at, rdata, 1'($urandom));
      checks++; if (obs_done !== 1'b1 || obs_stall !== exp_stall || obs_req !== exp_req) begin errors++; $display("[TB] FAIL rnd%0d_timing got=done%b stall%0d req%0d exp=done1 stall%0d req%0d", i, obs_done, obs_stall, obs_req, exp_stall, exp_req); end
      checks++; if ({obs_lv, obs_mis, obs_berr} !== {exp_lv, exp_mis, exp_berr} || obs_pulses !== 0) begin errors++; $display("[TB] FAIL rnd%0d_pulse got=%b%b%b early=%0d exp=%b%b%b early=0", i, obs_lv, obs_mis, obs_berr, obs_pulses, exp_lv, exp_mis, exp_berr); end
      checks++; if (obs_ld !== exp_ld) begin errors++; $display("[TB] FAIL rnd%0d_data got=%h exp=%h", i, obs_ld, exp_ld); end
      if (exp_req > 0) begin
        checks++; if (obs_addr !== exp_addr || obs_be !== exp_be || obs_we !== exp_we) begin errors++; $display("[TB] FAIL rnd%0d_bus got=%h/%b/%b exp=%h/%b/%b", i, obs_addr, obs_be, obs_we, exp_addr, exp_be, exp_we); end
        checks++; if (obs_wdata !== exp_wdata || obs_unstable !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_wdata got=%h unstable=%b exp=%h/0", i, obs_wdata, obs_unstable, exp_wdata); end
      end
    end
  endtask

  initial begin
    $display("[TB] mem_stage_lsu bench starting");
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the 5-stage RISC-V pipeline, reading the EX/MEM pipeline register and driving the data-memory bus. It decodes memread/memwrite/f3 into byte-lane-aligned bus transactions over a req/ready handshake, and stalls the pipeline until the access completes. It returns aligned, sign/zero-extended load data to the MEM/WB latch.

## Interface
- MAX_WAIT, 15: bus cycles without mem_ready before the access is aborted with bus_error (4-bit wait counter).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-low; clock clk.
- ex_memread  in  1  load request from EX/MEM.
- ex_memwrite  in  1  store request from EX/MEM.
- ex_f3  in  3  funct3: access size/sign.
- ex_aluresult  in  32  effective byte address.
- ex_bmux_result  in  32  store data (rs2).
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational.
- mem_req  out  1  bus request; registered.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, bits [1:0] forced to 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  bus completion strobe.
- mem_rdata  in  32  read data, valid when mem_ready.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse: load_data valid.
- misaligned  out  1  one-cycle pulse: misaligned/illegal access.
- bus_error  out  1  one-cycle pulse: timeout.

## Operation
- Access = ex_memread | ex_memwrite. If both are set, the access is a load and the store is dropped.
- Legal f3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - Any other f3 is illegal and is reported as misaligned.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
- States:
  - IDLE: on a legal access, register addr, be, wdata, we, f3 and go to BUSY. On an illegal or misaligned access, go to DONE_ERR. Otherwise stay in IDLE.
  - BUSY: mem_req=1. When mem_ready=1, capture mem_rdata and go to DONE. When the wait counter reaches MAX_WAIT without mem_ready, go to DONE_TO.
  - DONE, DONE_ERR, DONE_TO: one cycle each, then return to IDLE unconditionally. Inputs are not resampled in these states.
- stall = 1 in IDLE when an access is present, and 1 in BUSY. stall = 0 in all DONE states and during reset.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Loads: be follows the same lane rule as stores. Result = mem_rdata >> (8·addr[1:0]), truncated to the access size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- DONE:
  - load_valid=1 with load_data for loads.
  - Stores produce no pulse.
- DONE_ERR: misaligned=1, no bus activity, load_data=0.
- DONE_TO: bus_error=1, mem_req dropped, load_data=0.

## Timing
- Reset values: every registered output = 0 and the state is IDLE. A reset asserted mid-BUSY drops mem_req on the next edge and abandons the transfer.
- Handshake:
  - A transfer completes on the edge where mem_req & mem_ready.
  - mem_addr, mem_we, mem_wdata and mem_be stay stable while mem_req=1.
  - mem_req deasserts the cycle after completion.
  - mem_ready while mem_req=0 is ignored.
- Latency:
  - Access seen in cycle 0 (stall=1).
  - mem_req=1 from cycle 1.
  - With ready in cycle k≥1, DONE occurs in cycle k+1 with stall=0.
  - Minimum 2 stall cycles.
- Misaligned access: 1 stall cycle, then the pulse.
- Timeout: mem_req is held for MAX_WAIT cycles, then DONE_TO.
- The wait counter clears on entering BUSY and saturates; it does not wrap.
- In DONE states the EX/MEM latch advances at the end of the cycle, so the next instruction is first seen in the following IDLE cycle.

## Structure
- Package riscv_mem_pkg holds:
  - f3 encodings for LB/LH/LW/LBU/LHU/SB/SH/SW.
  - the state enum {IDLE, BUSY, DONE, DONE_ERR, DONE_TO}.
  - MAX_WAIT default.
- One combinational sub-module, load_extend (rdata, addr[1:0], f3 → load_data), shared with any future cache path.

## Test plan
- LW at 0x100, mem_ready in the 1st BUSY cycle, rdata 0xDEADBEEF → mem_addr 0x100, be 1111, load_data 0xDEADBEEF, exactly 2 stall cycles.
- LB at 0x203 with rdata 0x80112233 → be 1000, load_data 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x12 with rs2 0x0000ABCD → mem_we=1, be 1100, wdata 0xABCDABCD, addr 0x10, no load_valid.
- LW at 0x102 → misaligned pulse after 1 stall cycle, mem_req never asserted. f3=011 → same response.
- LW with mem_ready held low → mem_req high for 15 cycles, bus_error pulse, load_data 0, stall released.
- Reset low during BUSY → mem_req=0 and all outputs 0 next edge. A subsequent SW at 0x40 completes normally with be 1111.
